// File: rtl/mem_bus_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, AluOp load/store codes,
// FSM state encoding, hold-buffer payload and lane/alignment helpers.
package mem_bus_stage_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned SEL_W      = 4;

    typedef logic [REG_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

    localparam reg_bus_t      ZERO_WORD    = '0;
    localparam reg_addr_bus_t NOP_REG_ADDR = '0;

    localparam logic [ALUOP_W-1:0] OP_LB  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] OP_LH  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] OP_LW  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] OP_LBU = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] OP_LHU = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] OP_SB  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] OP_SH  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Raw completion kept while the stage is held; re-aligned on the way out.
    typedef struct packed {
        reg_addr_bus_t      wd;
        logic               wreg;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         addr_lo;
        reg_bus_t           rdata;
    } hold_t;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    // Big-endian lanes: address 0 is bits 31:24, i.e. sel[3].
    function automatic logic [SEL_W-1:0] lane_sel(input logic [ALUOP_W-1:0] op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b1000 >> a;
            OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b0011 : 4'b1100;
            default:              return 4'b1111;
        endcase
    endfunction

    function automatic reg_bus_t store_data(input logic [ALUOP_W-1:0] op, input reg_bus_t d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_stage_if.sv
// Single-outstanding request/acknowledge data bus between the MEM stage and memory.
interface mem_bus_stage_if;
    import mem_bus_stage_pkg::*;

    logic             bus_req;
    logic             bus_we;
    reg_bus_t         bus_addr;
    logic [SEL_W-1:0] bus_sel;
    reg_bus_t         bus_wdata;
    reg_bus_t         bus_rdata;
    logic             bus_ack;
    logic             bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a big-endian read word and extends it.
module mem_load_align
    import mem_bus_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  reg_bus_t           rdata,
    output reg_bus_t           load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = rdata[31:24];
        case (addr_lo)
            2'd1:    byte_c = rdata[23:16];
            2'd2:    byte_c = rdata[15:8];
            2'd3:    byte_c = rdata[7:0];
            default: byte_c = rdata[31:24];
        endcase
        half_c = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        load_data_c = ZERO_WORD;
        case (aluop)
            OP_LB:   load_data_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  load_data_c = {24'd0, byte_c};
            OP_LH:   load_data_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  load_data_c = {16'd0, half_c};
            OP_LW:   load_data_c = rdata;
            default: load_data_c = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: runs loads/stores over the req/ack bus, stalls the pipe
// while an access is in flight and presents the write-back triple to mem_wb.
module mem_bus_stage
    import mem_bus_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  reg_addr_bus_t      ex_wd,
    input  logic               ex_wreg,
    input  reg_bus_t           ex_wdata,
    input  logic [ALUOP_W-1:0] ex_aluop,
    input  reg_bus_t           ex_mem_addr,
    input  reg_bus_t           ex_reg2,
    output reg_addr_bus_t      mem_wd,
    output logic               mem_wreg,
    output reg_bus_t           mem_wdata,
    output logic               stallreq,
    mem_bus_stage_if.master    bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    reg_bus_t         addr_q, addr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    reg_bus_t         wdata_q, wdata_d;
    logic             err_q, err_d;
    hold_t            hold_q, hold_d;

    logic     is_mem_c, issue_c, ack_c, timeout_c, done_c, wb_wreg_c;
    reg_bus_t load_bus_c, load_hold_c;
    logic     unused_stall;

    assign unused_stall = ^{stall[5:4], stall[2:0]};

    mem_load_align u_align_bus (
        .aluop       (ex_aluop),
        .addr_lo     (ex_mem_addr[1:0]),
        .rdata       (bus.bus_rdata),
        .load_data_c (load_bus_c)
    );

    mem_load_align u_align_hold (
        .aluop       (hold_q.aluop),
        .addr_lo     (hold_q.addr_lo),
        .rdata       (hold_q.rdata),
        .load_data_c (load_hold_c)
    );

    // Access events; an ack in the last allowed cycle beats the timeout.
    always_comb begin
        is_mem_c  = is_load(ex_aluop) || is_store(ex_aluop);
        issue_c   = (state_q == ST_IDLE) && is_mem_c && !flush &&
                    !is_misaligned(ex_aluop, ex_mem_addr[1:0]);
        ack_c     = (state_q == ST_BUSY) && bus.bus_ack;
        timeout_c = (state_q == ST_BUSY) && !bus.bus_ack &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));
        done_c    = ack_c || timeout_c;
        wb_wreg_c = ack_c && ex_wreg && is_load(ex_aluop);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = is_store(ex_aluop);
                    addr_d  = {ex_mem_addr[REG_W-1:2], 2'b00};
                    sel_d   = lane_sel(ex_aluop, ex_mem_addr[1:0]);
                    wdata_d = store_data(ex_aluop, ex_reg2);
                end
            end
            ST_BUSY: begin
                if (done_c) begin
                    req_d   = 1'b0;
                    err_d   = timeout_c;
                    state_d = stall[3] ? ST_HOLD : ST_IDLE;
                    if (stall[3]) begin
                        hold_d = '{wd: ex_wd, wreg: wb_wreg_c, aluop: ex_aluop,
                                   addr_lo: ex_mem_addr[1:0], rdata: bus.bus_rdata};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!stall[3]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            err_d   = 1'b0;
            hold_d  = '0;
        end
    end

    // Write-back triple and stall request towards the pipeline.
    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        stallreq  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_mem_c) begin
                    mem_wreg = 1'b0;
                    stallreq = issue_c;
                end
            end
            ST_BUSY: begin
                mem_wreg  = wb_wreg_c;
                mem_wdata = is_load(ex_aluop) ? load_bus_c : ex_wdata;
                stallreq  = !done_c;
            end
            ST_HOLD: begin
                mem_wd    = hold_q.wd;
                mem_wreg  = hold_q.wreg;
                mem_wdata = load_hold_c;
            end
            default: ;
        endcase

        if (rst) begin
            mem_wd    = NOP_REG_ADDR;
            mem_wreg  = 1'b0;
            mem_wdata = ZERO_WORD;
            stallreq  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ZERO_WORD;
            sel_q   <= '0;
            wdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_err   = err_q;

endmodule
